seven_seg_scanner: RTL
======================

# seven_seg_scanner

Display-side consumer of the MM:SS BCD digits produced by the time-keeping logic. It snapshots the four digits once per scan frame, so a frame never mixes old and new digits. It time-multiplexes the digits onto a shared 4-digit common-anode 7-segment display with a ghosting guard, dash display for invalid codes, optional leading-zero blanking and a colon that blinks on the 1 Hz pulse. It sits between the time counter and the board pins.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ GUARD+2.
- GUARD, 16: cycles at the start of each slot with all anodes off.
- ACTIVE_LOW, 1: 1 = seg/dp/an driven active-low; 0 = active-high.
- BLANK_LZ, 1: 1 = blank minutes_tens when it is 0.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pulse  in  1  one-cycle 1 Hz tick; toggles colon.
- seconds_units  in  4  BCD digit 0 (rightmost).
- seconds_tens  in  4  BCD digit 1.
- minutes_units  in  4  BCD digit 2.
- minutes_tens  in  4  BCD digit 3 (leftmost).
- blank  in  1  level; forces all anodes inactive.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, used as colon on digit 2.
- an  out  4  digit enables, one-hot when active, an[i] selects digit i.
- frame_done  out  1  one-cycle strobe at each frame wrap.

## Operation
- Prescaler pcnt counts 0..REFRESH_DIV-1 and wraps. On its terminal count, digit index idx advances 0→1→2→3→0.
- Snapshot: when idx wraps 3→0, all four inputs load into shadow registers snap[0..3] in the same edge, and frame_done=1 for that cycle. Live inputs are never displayed directly.
- Decode per snap[idx]:
  - 0–9 → standard font.
  - 10–15 → dash (g only).
  - idx=3 with BLANK_LZ=1 and snap[3]=0 → all segments off.
- Colon: colon_reg toggles on every cycle with pulse=1. dp is active only when idx=2 and colon_reg=1.
- Guard: while pcnt < GUARD, an is all inactive. Otherwise an is one-hot on idx, unless blank is high, in which case an stays all inactive.
- Polarity inversion (ACTIVE_LOW) is applied at the output registers only; internal logic is active-high.
- Reset (any cycle, including mid-frame) on next edge: pcnt=0, idx=0, snap[*]=0, colon_reg=0. Outputs go to an=all inactive, seg=all off, dp=off, frame_done=0. Inputs are ignored during the reset cycle.

## Timing
- seg, dp and an are registered: they reflect idx/pcnt/blank/colon_reg one cycle after those change.
- Slot length is exactly REFRESH_DIV cycles; frame length is 4·REFRESH_DIV.
- After reset release, the first slot is idx 0 showing snap=0. The first real snapshot is at the first 3→0 wrap.
- Input-to-display latency is at most 4·REFRESH_DIV+1 cycles.
- frame_done is asserted in the same cycle that snap loads; snap values are visible on seg one cycle later, inside the guard window.
- pulse coinciding with a slot or frame wrap: both take effect on that edge, independently.
- blank takes effect one cycle after it is applied (registered path); pcnt/idx keep running while blanked.

## Structure
- Shared package seg_pkg:
  - 7-bit font constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - 2-bit digit-index typedef.
  - Constant COLON_DIGIT = 2.
- Sub-module bcd_to_seg: combinational 4-bit → 7-bit decoder (invalid → dash, plus blank input). Instantiate once, fed by snap[idx].
- Top level holds the prescaler, idx counter, snapshot registers, colon toggle, guard compare and output registers.

## Test plan
Use REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1 in sim.
- Reset: hold rst 3 cycles mid-frame → next edge an=4'b1111, seg=7'h7F, dp=1, frame_done=0; idx restarts at 0.
- Scan: inputs 1,2,3,4 (s_u..m_t) held → after first frame_done, the slots show fonts 1,2,3,4 on an=1110,1101,1011,0111. Anodes are off for the first 2 cycles of each slot, and each slot is 8 cycles.
- Snapshot integrity: change seconds_units 5→6 mid-frame → 5 is shown for the rest of that frame; 6 appears only after the next frame_done.
- Leading zero / invalid: minutes_tens=0 with BLANK_LZ=1 → digit 3 shows all segments off. seconds_tens=10 → digit 1 shows dash (seg=7'b0111111 active-low).
- Colon: 3 pulses → colon_reg=1; dp is low only during the idx=2 slot. A pulse coincident with a frame wrap toggles colon and loads snap on the same edge.
- Blank: assert blank for 20 cycles → an=1111 from the cycle after assertion. idx keeps advancing, and the display resumes mid-frame on the correct digit after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: active-high fonts (bit 0 = a,
// bit 6 = g), the digit-index type and the position of the colon.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t COLON_DIGIT = 2'd2;
  localparam digit_idx_t LAST_DIGIT  = 2'd3;

  // One-hot anode pattern for a digit position, active-high.
  function automatic logic [3:0] idx_onehot(input digit_idx_t i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder, active-high output. Codes 10-15 show a
// dash so corrupted digits are visible; blank overrides everything.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed MM:SS driver for a 4-digit 7-segment display. Digits are
// snapshotted once per frame so a frame never mixes old and new values.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  input  logic [3:0] seconds_units,
  input  logic [3:0] seconds_tens,
  input  logic [3:0] minutes_units,
  input  logic [3:0] minutes_tens,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int unsigned PCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  function automatic logic [6:0] pol7(input logic [6:0] v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [3:0] pol4(input logic [3:0] v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic pol1(input logic v);
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // Stage p0: scan state (prescaler, digit index, shadow digits, colon)
  logic [PCNT_W-1:0] pcnt_p0;
  digit_idx_t        idx_p0;
  logic [3:0]        snap_p0 [4];
  logic              colon_p0;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (pcnt_p0 == PCNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx_p0 == LAST_DIGIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_p0  <= '0;
      idx_p0   <= '0;
      colon_p0 <= 1'b0;
      for (int i = 0; i < 4; i++) snap_p0[i] <= 4'd0;
    end else begin
      pcnt_p0 <= slot_end ? '0 : pcnt_p0 + PCNT_W'(1);
      if (slot_end) idx_p0 <= idx_p0 + 2'd1;
      if (frame_end) begin
        snap_p0[0] <= seconds_units;
        snap_p0[1] <= seconds_tens;
        snap_p0[2] <= minutes_units;
        snap_p0[3] <= minutes_tens;
      end
      // Pulse toggles independently of any slot or frame wrap on the same edge.
      if (pulse) colon_p0 <= ~colon_p0;
    end
  end

  logic [3:0] cur_digit;
  logic       lz_blank;
  logic [6:0] seg_dec;
  logic [3:0] an_next;
  logic       dp_next;

  assign cur_digit = snap_p0[idx_p0];
  assign lz_blank  = (BLANK_LZ != 0) && (idx_p0 == LAST_DIGIT) && (cur_digit == 4'd0);

  bcd_to_seg u_dec (
    .bcd   (cur_digit),
    .blank (lz_blank),
    .seg   (seg_dec)
  );

  // Anodes stay dark during the guard window so the previous digit's segments
  // never ghost onto the newly selected anode.
  assign an_next = ((pcnt_p0 < PCNT_W'(GUARD)) || blank) ? 4'b0000 : idx_onehot(idx_p0);
  assign dp_next = (idx_p0 == COLON_DIGIT) && colon_p0;

  // Stage p1: output registers, polarity applied here only
  logic [6:0] seg_p1;
  logic       dp_p1;
  logic [3:0] an_p1;
  logic       frame_done_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1        <= pol7(SEG_OFF);
      dp_p1         <= pol1(1'b0);
      an_p1         <= pol4(4'b0000);
      frame_done_p1 <= 1'b0;
    end else begin
      seg_p1        <= pol7(seg_dec);
      dp_p1         <= pol1(dp_next);
      an_p1         <= pol4(an_next);
      frame_done_p1 <= frame_end;
    end
  end

  assign seg        = seg_p1;
  assign dp         = dp_p1;
  assign an         = an_p1;
  assign frame_done = frame_done_p1;

endmodule
